multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: 8..64, power of two).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept request.
REQ-006 SHALL have port op  input  4  operation code (REQ-012).
REQ-007 SHALL have ports src_a, src_b  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have ports flags  output  4  {CF,ZF,SF,OF}, and illegal  output  1  op not supported.

Function
REQ-012 Op codes SHALL be 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL (low half), 11 MULHU, 12 DIVU, 13 REMU; 14-15 illegal.
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 Request SHALL be accepted when in_valid && in_ready; operands and op are registered at acceptance and later input changes are ignored.
REQ-015 Ops 0-9, illegal codes, and divide-by-zero SHALL go IDLE->DONE (result valid the cycle after acceptance).
REQ-016 Ops 10-13 with nonzero divisor SHALL go IDLE->BUSY, iterate one bit per cycle for exactly WIDTH cycles, then DONE; out_valid rises WIDTH+1 cycles after acceptance.
REQ-017 DONE SHALL hold result, flags, and illegal stable until out_ready; on out_valid && out_ready, state SHALL return to IDLE (next acceptance no earlier than the following cycle).
REQ-018 SUB SHALL compute src_a + ~src_b + 1; CF = carry-out (1 = no borrow); OF = signed overflow; CF and OF SHALL be 0 for all other ops.
REQ-019 SLT SHALL return {0..,SF_sub ^ OF_sub}; SLTU SHALL return {0..,~CF_sub}.
REQ-020 Shift amount SHALL be src_b[log2(WIDTH)-1:0]; SRA SHALL replicate src_a MSB.
REQ-021 ZF SHALL be (result==0) and SF SHALL be result[WIDTH-1] for every op.
REQ-022 DIVU by zero SHALL return all ones; REMU by zero SHALL return src_a; no flag beyond REQ-021.
REQ-023 Illegal op SHALL return result 0, flags 0, and illegal=1; illegal SHALL be 0 otherwise.

Reset
REQ-024 reset SHALL force state IDLE asynchronously, abort any BUSY operation, and clear result, flags, illegal, and iteration counter to 0; out_valid=0, in_ready=1 while reset deasserted-after.
REQ-025 First acceptance SHALL be possible on the first clk edge after reset deassertion.

Configuration
REQ-026 Macro MULTICYCLE_ALU_MULDIV_EN SHALL compile in ops 10-13 and the iterative engine.
REQ-027 Without MULTICYCLE_ALU_MULDIV_EN, ops 10-13 SHALL behave as illegal (REQ-023, one-cycle latency), state BUSY SHALL be unreachable, and no engine logic SHALL be instantiated.

Structure
REQ-028 Package alu_pkg SHALL hold the op-code enum, the flags struct {CF,ZF,SF,OF}, and the FSM state enum.
REQ-029 Shift-add multiplier / restoring divider SHALL be sub-module alu_iter_muldiv (start, op, operands in; done, result out), instantiated only under REQ-026.

Verification (WIDTH=32)
REQ-030 ADD 0x7FFFFFFF+1 -> result 0x80000000, OF=1, SF=1, CF=0, out_valid 1 cycle after acceptance.
REQ-031 SLT 0x80000000 vs 1 -> 1; SLTU same operands -> 0; SUB 5-5 -> 0, ZF=1, CF=1.
REQ-032 MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU -> 0xFFFFFFFE; out_valid exactly 33 cycles after acceptance, in_ready low throughout.
REQ-033 DIVU 100/7 -> 14, REMU -> 2; DIVU x/0 -> 0xFFFFFFFF in 1 cycle; REMU 0x1234/0 -> 0x1234.
REQ-034 Hold out_ready low 5 cycles in DONE -> result stable, in_ready low; reset asserted mid-BUSY -> IDLE immediately, out_valid 0, next request completes correctly.
REQ-035 op=15 -> illegal=1, result 0; build without MULTICYCLE_ALU_MULDIV_EN, op=10 -> illegal=1 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for multicycle_alu: op codes, flag bundle, control FSM states
// and the op selector understood by the iterative mul/div engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic cf;
    logic zf;
    logic sf;
    logic of;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // {is_div, high/remainder half}: maps directly from op[2] and op[0] of ops 10-13
  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiplier and restoring divider, one bit per cycle,
// WIDTH iterations after start_i; done_o is raised once the last iteration is stored.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  logic             busy_q, busy_d;
  logic             is_div_q, is_div_d;
  logic             sel_hi_q, sel_hi_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   rem_shift_s;
  logic             sub_ok_s;
  logic             last_s;

  assign last_s   = (cnt_q == CNTW'(WIDTH));
  assign done_o   = busy_q && last_s;
  // {hi,lo} holds product high/low for multiply and remainder/quotient for divide
  assign result_o = sel_hi_q ? hi_q : lo_q;

  // one iteration step of the selected algorithm
  always_comb begin
    mul_sum_s   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
    rem_shift_s = {hi_q, lo_q[WIDTH-1]};
    sub_ok_s    = (rem_shift_s >= {1'b0, opnd_q});

    busy_d   = busy_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;

    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = {CNTW{1'b0}};
      is_div_d = op_i[1];
      sel_hi_d = op_i[0];
      hi_d     = {WIDTH{1'b0}};
      lo_d     = a_i;
      opnd_d   = b_i;
    end else if (busy_q && last_s) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q + CNTW'(1);
      if (is_div_q) begin
        hi_d = sub_ok_s ? (rem_shift_s[WIDTH-1:0] - opnd_q) : rem_shift_s[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], sub_ok_s};
      end else begin
        hi_d = mul_sum_s[WIDTH:1];
        lo_d = {mul_sum_s[0], lo_q[WIDTH-1:1]};
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // engine registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      cnt_q    <= {CNTW{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
    end else begin
      busy_q   <= busy_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with valid/ready handshake. Define MULTICYCLE_ALU_MULDIV_EN to
// build in MUL/MULHU/DIVU/REMU and the iterative engine; otherwise ops 10-13 are illegal.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             illegal_q, illegal_d;

  alu_op_e          op_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic             add_of_s, sub_of_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] fast_res_s;
  logic             fast_cf_s, fast_of_s, fast_ill_s, multi_s;
  logic             eng_done_s;
  logic [WIDTH-1:0] eng_result_s;

  assign op_s      = alu_op_e'(op);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

  // single-cycle datapath, evaluated on the live inputs and captured at acceptance
  always_comb begin
    add_s    = {1'b0, src_a} + {1'b0, src_b};
    sub_s    = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
    add_of_s = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (add_s[WIDTH-1] != src_a[WIDTH-1]);
    sub_of_s = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sub_s[WIDTH-1] != src_a[WIDTH-1]);
    shamt_s  = src_b[SHW-1:0];

    fast_res_s = {WIDTH{1'b0}};
    fast_cf_s  = 1'b0;
    fast_of_s  = 1'b0;
    fast_ill_s = 1'b0;
    multi_s    = 1'b0;

    case (op_s)
      OP_ADD: begin
        fast_res_s = add_s[WIDTH-1:0];
        fast_cf_s  = add_s[WIDTH];
        fast_of_s  = add_of_s;
      end
      OP_SUB: begin
        fast_res_s = sub_s[WIDTH-1:0];
        fast_cf_s  = sub_s[WIDTH];
        fast_of_s  = sub_of_s;
      end
      OP_AND:  fast_res_s = src_a & src_b;
      OP_OR:   fast_res_s = src_a | src_b;
      OP_XOR:  fast_res_s = src_a ^ src_b;
      OP_SLT:  fast_res_s = {{(WIDTH-1){1'b0}}, sub_s[WIDTH-1] ^ sub_of_s};
      OP_SLTU: fast_res_s = {{(WIDTH-1){1'b0}}, ~sub_s[WIDTH]};
      OP_SLL:  fast_res_s = src_a << shamt_s;
      OP_SRL:  fast_res_s = src_a >> shamt_s;
      OP_SRA:  fast_res_s = $unsigned($signed(src_a) >>> shamt_s);
`ifdef MULTICYCLE_ALU_MULDIV_EN
      OP_MUL, OP_MULHU: multi_s = 1'b1;
      // divide-by-zero is resolved here so it completes in one cycle
      OP_DIVU: begin
        if (src_b == {WIDTH{1'b0}}) begin
          fast_res_s = {WIDTH{1'b1}};
        end else begin
          multi_s = 1'b1;
        end
      end
      OP_REMU: begin
        if (src_b == {WIDTH{1'b0}}) begin
          fast_res_s = src_a;
        end else begin
          multi_s = 1'b1;
        end
      end
`endif
      default: fast_ill_s = 1'b1;
    endcase
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  md_op_e md_op_s;
  logic   start_s;

  assign md_op_s = md_op_e'({op[2], op[0]});
  assign start_s = (state_q == ST_IDLE) && in_valid && multi_s;

  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_s),
    .op_i    (md_op_s),
    .a_i     (src_a),
    .b_i     (src_b),
    .done_o  (eng_done_s),
    .result_o(eng_result_s)
  );
`else
  assign eng_done_s   = 1'b0;
  assign eng_result_s = {WIDTH{1'b0}};
`endif

  // control FSM next state and result capture
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && multi_s) begin
          state_d = ST_BUSY;
        end else if (in_valid) begin
          state_d    = ST_DONE;
          result_d   = fast_res_s;
          illegal_d  = fast_ill_s;
          flags_d.cf = fast_cf_s;
          flags_d.zf = (fast_res_s == {WIDTH{1'b0}}) && !fast_ill_s;
          flags_d.sf = fast_res_s[WIDTH-1];
          flags_d.of = fast_of_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (eng_done_s) begin
          state_d    = ST_DONE;
          result_d   = eng_result_s;
          illegal_d  = 1'b0;
          flags_d.cf = 1'b0;
          flags_d.zf = (eng_result_s == {WIDTH{1'b0}});
          flags_d.sf = eng_result_s[WIDTH-1];
          flags_d.of = 1'b0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= {WIDTH{1'b0}};
      flags_q   <= alu_flags_t'(4'b0000);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
